// File: rtl/mem_access_ctrl.sv
// Memory access controller: accepts single-word writes and 1..4 beat read
// bursts from a core and sequences them onto a combinational word store.
module mem_access_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] beats_left;

  // mem_address doubles as the latched request address and the running
  // beat address, so every strobe is driven straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beats_left  <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_last   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            mem_address <= req_addr;
            mem_wdata   <= req_wdata;
            beats_left  <= req_len;
            if (req_write) begin
              mem_write <= 1'b1;
              state     <= WRITE;
            end else begin
              mem_read <= 1'b1;
              state    <= READ;
            end
          end
        end

        WRITE: begin
          mem_write <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        READ: begin
          mem_read   <= 1'b0;
          resp_data  <= mem_rdata;
          resp_valid <= 1'b1;
          resp_last  <= (beats_left == 2'd0);
          state      <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            if (beats_left != 2'd0) begin
              beats_left  <= beats_left - 2'd1;
              mem_address <= mem_address + ADDR_W'(1);
              mem_read    <= 1'b1;
              state       <= READ;
            end else begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural word store attached.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [4:0] req_addr;
  logic [1:0] req_len;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic       resp_last;
  logic       mem_read;
  logic       mem_write;
  logic [4:0] mem_address;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [32];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  int last_wr_cyc = 0;

  mem_access_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_address];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) begin
      mem[mem_address] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts in IDLE; ends in IDLE with the write committed to the store.
  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    tick;
    req_valid = 1'b0;
    chk("wr_strobe", 32'(mem_write), 32'd1);
    chk("wr_addr", 32'(mem_address), 32'(a));
    chk("wr_data", 32'(mem_wdata), 32'(d));
    chk("wr_busy", 32'(req_ready), 32'd0);
    last_wr_cyc = cyc;
    tick;
    chk("wr_end", 32'(mem_write), 32'd0);
    chk("wr_ready", 32'(req_ready), 32'd1);
  endtask

  // Starts at the beginning of a READ cycle; ends just after the handshake.
  task automatic read_beat(input logic [7:0] d, input logic [4:0] a, input logic last);
    chk("rd_strobe", 32'(mem_read), 32'd1);
    chk("rd_addr", 32'(mem_address), 32'(a));
    chk("rd_novalid", 32'(resp_valid), 32'd0);
    tick;
    chk("rd_valid", 32'(resp_valid), 32'd1);
    chk("rd_data", 32'(resp_data), 32'(d));
    chk("rd_last", 32'(resp_last), 32'(last));
    chk("rd_idle_strobe", 32'(mem_read), 32'd0);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask

  task automatic start_read(input logic [4:0] a, input logic [1:0] len);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = len;
    tick;
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, rc, wc;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_len = '0; req_wdata = '0; resp_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_last", 32'(resp_last), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    // Single write then single-beat read back.
    wc = wr_cnt;
    do_write(5'd5, 8'hA7);
    chk("one_write_pulse", 32'(wr_cnt - wc), 32'd1);
    chk("store_5", 32'(mem[5]), 32'hA7);
    start_read(5'd5, 2'd0);
    read_beat(8'hA7, 5'd5, 1'b1);
    chk("single_done_ready", 32'(req_ready), 32'd1);
    chk("single_done_valid", 32'(resp_valid), 32'd0);

    // Wrapping 4-beat burst.
    do_write(5'd30, 8'h11);
    do_write(5'd31, 8'h22);
    do_write(5'd0, 8'h33);
    do_write(5'd1, 8'h44);
    start_read(5'd30, 2'd3);
    read_beat(8'h11, 5'd30, 1'b0);
    read_beat(8'h22, 5'd31, 1'b0);
    read_beat(8'h33, 5'd0, 1'b0);
    read_beat(8'h44, 5'd1, 1'b1);
    chk("wrap_done_ready", 32'(req_ready), 32'd1);

    // Stall the second beat for five cycles.
    start_read(5'd30, 2'd2);
    read_beat(8'h11, 5'd30, 1'b0);
    chk("stall_rd_addr", 32'(mem_address), 32'd31);
    tick;
    rc = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_data", 32'(resp_data), 32'h22);
      chk("stall_last", 32'(resp_last), 32'd0);
      tick;
    end
    chk("stall_no_reads", 32'(rd_cnt - rc), 32'd0);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    read_beat(8'h33, 5'd0, 1'b1);

    // resp_ready held high throughout, with a write request pending behind the burst.
    resp_ready = 1'b1;
    rc = rd_cnt;
    wc = wr_cnt;
    start_read(5'd0, 2'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd2; req_wdata = 8'h55;
    chk("held_r1_strobe", 32'(mem_read), 32'd1);
    chk("held_r1_addr", 32'(mem_address), 32'd0);
    tick;
    chk("held_b1_valid", 32'(resp_valid), 32'd1);
    chk("held_b1_data", 32'(resp_data), 32'h33);
    chk("held_b1_last", 32'(resp_last), 32'd0);
    chk("held_b1_busy", 32'(req_ready), 32'd0);
    tick;
    chk("held_r2_strobe", 32'(mem_read), 32'd1);
    chk("held_r2_addr", 32'(mem_address), 32'd1);
    chk("held_r2_novalid", 32'(resp_valid), 32'd0);
    tick;
    chk("held_b2_data", 32'(resp_data), 32'h44);
    chk("held_b2_last", 32'(resp_last), 32'd1);
    tick;
    chk("held_idle_ready", 32'(req_ready), 32'd1);
    chk("held_no_write_yet", 32'(wr_cnt - wc), 32'd0);
    chk("held_two_reads", 32'(rd_cnt - rc), 32'd2);
    tick;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    chk("queued_write_strobe", 32'(mem_write), 32'd1);
    chk("queued_write_addr", 32'(mem_address), 32'd2);
    chk("queued_write_data", 32'(mem_wdata), 32'h55);
    tick;
    chk("queued_store", 32'(mem[2]), 32'h55);

    // Reset during RESP of a 4-beat burst.
    start_read(5'd30, 2'd3);
    tick;
    chk("prerst_valid", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    resp_ready = 1'b1;
    chk("rrst_req_ready", 32'(req_ready), 32'd1);
    chk("rrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rrst_resp_data", 32'(resp_data), 32'd0);
    chk("rrst_resp_last", 32'(resp_last), 32'd0);
    chk("rrst_mem_read", 32'(mem_read), 32'd0);
    chk("rrst_mem_address", 32'(mem_address), 32'd0);
    chk("rrst_mem_wdata", 32'(mem_wdata), 32'd0);
    rc = rd_cnt;
    tick; tick; tick;
    chk("rrst_no_beats", 32'(resp_valid), 32'd0);
    chk("rrst_no_reads", 32'(rd_cnt - rc), 32'd0);
    chk("rrst_still_ready", 32'(req_ready), 32'd1);
    resp_ready = 1'b0;

    // Reset during WRITE.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd3; req_wdata = 8'h99;
    tick;
    req_valid = 1'b0;
    chk("wrst_in_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("wrst_strobe_clear", 32'(mem_write), 32'd0);
    wc = wr_cnt;
    tick; tick;
    chk("wrst_no_pulse", 32'(wr_cnt - wc), 32'd0);

    // Back-to-back writes.
    do_write(5'd0, 8'hAA);
    w0 = last_wr_cyc;
    do_write(5'd1, 8'hBB);
    chk("b2b_spacing", 32'(last_wr_cyc - w0), 32'd2);
    chk("b2b_store0", 32'(mem[0]), 32'hAA);
    chk("b2b_store1", 32'(mem[1]), 32'hBB);

    chk("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
